low_trace_observer: RTL

Downstream observer for the info-flow test programs. It watches the public side of a program stage (`low`, `PC`, `halt`) every cycle and timestamps each change of the low output into a small event FIFO. It records cycles-to-halt and an optional trace signature, so a bench or a second copy can compare low-observable behaviour across runs with different high inputs. The drain port is valid/ready.

---
 rtl/low_trace_observer.sv | 114 +++++++++++
 1 files changed

// File: rtl/low_trace_observer.sv
// Low-side observer: timestamps obs_low changes into a DEPTH-entry FIFO drained by valid/ready; records halt cycle and event count.
// Optional trace signature built when LTO_SIGNATURE_EN is defined; otherwise sig is tied to 0.
module low_trace_observer #(
    parameter int DEPTH = 4,
    parameter int TS_W  = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            obs_low,
    input  logic [2:0]      obs_pc,
    input  logic            obs_halt,
    output logic            ev_valid,
    input  logic            ev_ready,
    output logic [TS_W:0]   ev_data,
    output logic            done,
    output logic [TS_W-1:0] cycles,
    output logic [7:0]      ev_total,
    output logic            overflow,
    output logic [7:0]      sig
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {RUN, HALTED} state_t;

    state_t          state;
    logic [TS_W:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [TS_W-1:0] cyc;
    logic            prev_low;

    logic run, event_hit, full, pop, push;

    assign run       = (state == RUN);
    assign event_hit = run && (obs_low != prev_low);
    assign full      = (count == CW'(DEPTH));
    assign pop       = ev_valid && ev_ready;
    // A full FIFO still accepts when the head leaves on the same edge.
    assign push      = event_hit && (!full || pop);

    // Outputs depend only on registered state.
    assign ev_valid = (count != '0);
    assign ev_data  = ev_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {obs_low, cyc};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= RUN;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            cyc      <= '0;
            prev_low <= 1'b0;
            done     <= 1'b0;
            cycles   <= '0;
            ev_total <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (event_hit) begin
                if (ev_total != 8'hFF) begin
                    ev_total <= ev_total + 8'd1;
                end
                if (full && !pop) begin
                    overflow <= 1'b1;
                end
            end
            if (run) begin
                prev_low <= obs_low;
                if (cyc != '1) begin
                    cyc <= cyc + TS_W'(1);
                end
                if (obs_halt) begin
                    state  <= HALTED;
                    done   <= 1'b1;
                    cycles <= cyc;
                end
            end
        end
    end

`ifdef LTO_SIGNATURE_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sig <= '0;
        end else if (run) begin
            sig <= {sig[6:0], sig[7]} ^ {4'b0, obs_low, obs_pc};
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^obs_pc;
    assign sig       = '0;
`endif

endmodule
